// File: rtl/prime_bus_master.sv
// prime_bus_master: fetches the Nth prime from a memory-mapped prime engine.
// A request writes N to the argument register and polls the status register
// until the engine reports done. It then reads the result register and
// returns it on a valid/ready response port.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_valid/req_ready request handshake; req_n is the 1-based prime index
//   rsp_valid/rsp_ready response handshake; rsp_prime, rsp_n, rsp_err
//   busy                high whenever the master is not idle
//   m_addr, m_wr, m_rd, m_wdata, m_rdata
//                       slave bus; the slave acts on the rising edge of a strobe
module prime_bus_master #(
    parameter logic [15:0] ADDR_A   = 16'h288,  // argument register
    parameter logic [15:0] ADDR_W   = 16'h298,  // result register
    parameter logic [15:0] ADDR_S   = 16'h2A0,  // status register
    parameter int unsigned POLL_GAP = 4,        // idle cycles between polls, >= 1
    parameter int unsigned TIMEOUT  = 65535     // poll cycle limit, >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [9:0]  req_n,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_prime,
    output logic [9:0]  rsp_n,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] m_addr,
    output logic        m_wr,
    output logic        m_rd,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int unsigned TMO_W = 17;
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
    localparam logic [2:0]       STATUS_DONE = 3'b000;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        POLL_SETUP,
        POLL_STROBE,
        POLL_SAMPLE,
        POLL_WAIT,
        RD_SETUP,
        RD_STROBE,
        RD_SAMPLE,
        RESP
    } state_t;

    state_t             state;
    logic [9:0]         n_q;
    logic               second_beat;   // strobe states last two cycles
    logic [GAP_W-1:0]   gap_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic in_poll;
    logic tmo_hit;
    logic [TMO_W-1:0] tmo_inc;

    // Poll-phase qualifiers for the timeout watchdog
    assign in_poll = (state == POLL_SETUP) || (state == POLL_STROBE) ||
                     (state == POLL_SAMPLE) || (state == POLL_WAIT);
    // This poll cycle is the TIMEOUT-th one since the write finished
    assign tmo_hit = (tmo_cnt >= TMO_LAST);
    assign tmo_inc = (tmo_cnt == {TMO_W{1'b1}}) ? tmo_cnt : tmo_cnt + TMO_W'(1);

    // Controller: state and all outputs are registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            n_q         <= '0;
            second_beat <= 1'b0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_prime   <= '0;
            rsp_n       <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            m_addr      <= '0;
            m_wr        <= 1'b0;
            m_rd        <= 1'b0;
            m_wdata     <= '0;
        end else if (in_poll && tmo_hit) begin
            // Engine never reported done: give up with an error response
            state     <= RESP;
            m_rd      <= 1'b0;
            m_wr      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_prime <= '0;
            rsp_err   <= 1'b1;
            rsp_n     <= n_q;
        end else begin
            if (in_poll) begin
                tmo_cnt <= tmo_inc;
            end

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        n_q       <= req_n;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_n == 10'd0) begin
                            // Index 0 has no prime: reject without bus traffic
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_prime <= '0;
                            rsp_err   <= 1'b1;
                            rsp_n     <= req_n;
                        end else begin
                            state   <= WR_SETUP;
                            m_addr  <= ADDR_A;
                            m_wdata <= {22'b0, req_n};
                        end
                    end
                end

                WR_SETUP: begin
                    state       <= WR_STROBE;
                    m_wr        <= 1'b1;
                    second_beat <= 1'b0;
                end

                WR_STROBE: begin
                    if (!second_beat) begin
                        second_beat <= 1'b1;
                    end else begin
                        // Slave latched the argument on the rising edge
                        state   <= POLL_SETUP;
                        m_wr    <= 1'b0;
                        m_addr  <= ADDR_S;
                        tmo_cnt <= '0;
                    end
                end

                POLL_SETUP: begin
                    state       <= POLL_STROBE;
                    m_rd        <= 1'b1;
                    second_beat <= 1'b0;
                end

                POLL_STROBE: begin
                    if (!second_beat) begin
                        second_beat <= 1'b1;
                    end else begin
                        state <= POLL_SAMPLE;
                        m_rd  <= 1'b0;
                    end
                end

                POLL_SAMPLE: begin
                    // Address held here; only the low status bits matter
                    if (m_rdata[2:0] == STATUS_DONE) begin
                        state  <= RD_SETUP;
                        m_addr <= ADDR_W;
                    end else begin
                        state   <= POLL_WAIT;
                        gap_cnt <= '0;
                    end
                end

                POLL_WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= POLL_SETUP;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                RD_SETUP: begin
                    state       <= RD_STROBE;
                    m_rd        <= 1'b1;
                    second_beat <= 1'b0;
                end

                RD_STROBE: begin
                    if (!second_beat) begin
                        second_beat <= 1'b1;
                    end else begin
                        state <= RD_SAMPLE;
                        m_rd  <= 1'b0;
                    end
                end

                RD_SAMPLE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_prime <= m_rdata;
                    rsp_err   <= 1'b0;
                    rsp_n     <= n_q;
                end

                RESP: begin
                    // Response fields are frozen until the consumer takes them
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/prime_bus_master.md
PRIME_BUS_MASTER -- requirements
Module: prime_bus_master

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_A, 16'h288, argument register address
- ADDR_W, 16'h298, result register address
- ADDR_S, 16'h2A0, status register address
- POLL_GAP, 4, idle cycles between status polls (min 1)
- TIMEOUT, 65535, max cycles from write strobe end to done status
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock
- reset, in, 1, synchronous active-high reset
- req_valid, in, 1, request present
- req_n, in, 10, index N of wanted prime (1-based)
- req_ready, out, 1, request accepted when high with req_valid
- rsp_valid, out, 1, response present
- rsp_ready, in, 1, consumer accepts response
- rsp_prime, out, 32, Nth prime, 0 on error
- rsp_n, out, 10, echo of req_n
- rsp_err, out, 1, 1 = rejected (N=0) or timed out
- busy, out, 1, high in every state except IDLE
- m_addr, out, 16, slave bus address
- m_wr, out, 1, write strobe (slave acts on rising edge)
- m_rd, out, 1, read strobe (slave acts on rising edge)
- m_wdata, out, 32, write data
- m_rdata, in, 32, read data from slave
REQ-003 The block SHALL use one clock (clk) and a synchronous active-high reset (reset); all outputs are registered.

Function
REQ-004 FSM states SHALL be: IDLE, WR_SETUP, WR_STROBE, POLL_SETUP, POLL_STROBE, POLL_SAMPLE, POLL_WAIT, RD_SETUP, RD_STROBE, RD_SAMPLE, RESP.
REQ-005 req_ready SHALL be high only in IDLE; a handshake (req_valid & req_ready) latches req_n, and only one request is outstanding.
REQ-006 On handshake with req_n=0, the FSM SHALL go directly to RESP with rsp_prime=0, rsp_err=1, no bus cycles.
REQ-007 On handshake with req_n!=0, the FSM SHALL go to WR_SETUP: m_addr=ADDR_A, m_wdata={22'b0,req_n}, strobes low, 1 cycle.
REQ-008 Each bus access SHALL be SETUP (1 cycle, address stable, strobes low), STROBE (2 cycles, strobe high, address stable), then strobe low; address stays stable 1 cycle after strobe falls.
REQ-009 After WR_STROBE, the FSM SHALL enter POLL_SETUP, reading ADDR_S; in POLL_SAMPLE it captures m_rdata[2:0].
REQ-010 Status 3'b000 (IDLE) SHALL mean done -> RD_SETUP; any other value -> POLL_WAIT for POLL_GAP cycles -> POLL_SETUP.
REQ-011 RD access SHALL read ADDR_W; at RD_SAMPLE, rsp_prime <= m_rdata, rsp_err <= 0, go to RESP.
REQ-012 Timeout counter (17 bits, saturating) SHALL clear at WR_STROBE exit and increment each cycle in POLL_*; reaching TIMEOUT in any POLL_* state -> RESP with rsp_prime=0, rsp_err=1, strobes driven low the same cycle.
REQ-013 In RESP, rsp_valid SHALL be high; rsp_prime/rsp_n/rsp_err stay stable until rsp_ready; on handshake -> IDLE next cycle, rsp_valid low.
REQ-014 m_wr and m_rd SHALL never be high simultaneously and SHALL be low outside STROBE states.
REQ-015 busy SHALL equal (state != IDLE); a new request is accepted earliest the cycle after the response handshake.

Reset
REQ-016 While reset is high at a clk edge: state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_prime=0, rsp_n=0, rsp_err=0, busy=0, m_addr=0, m_wr=0, m_rd=0, m_wdata=0, timeout counter=0.
REQ-017 Reset mid-operation SHALL abort without emitting a response; strobes are low from the first cycle after the reset edge.

Verification
REQ-018 req_n=1, slave model status 1 for 3 polls then 0, W=2 -> one write of 0x001 to 0x288, 4 status reads, one read of 0x298, rsp_prime=2, rsp_err=0.
REQ-019 req_n=10, W=29 -> rsp_prime=29, rsp_n=10; m_wr high exactly 2 cycles, m_rd never overlapping m_wr.
REQ-020 req_n=0 -> rsp_valid within 2 cycles, rsp_err=1, rsp_prime=0, m_wr/m_rd never asserted.
REQ-021 TIMEOUT=100, status stuck at 3 -> rsp_err=1, rsp_prime=0 after 100 poll cycles (+/-1); no read of 0x298.
REQ-022 rsp_ready low 5 cycles -> rsp_* stable, req_ready low; second request accepted only after handshake.
REQ-023 reset asserted in POLL_STROBE -> m_rd low next cycle, no rsp_valid, new request accepted normally.
